// File: rtl/hex_display_ctrl_if.sv
// Control and display bus of the hex display controller.
interface hex_display_ctrl_if #(
  parameter int unsigned DIGITS = 4
);

  logic                  Load;
  logic [4*DIGITS-1:0]   Data;
  logic                  CountEn;
  logic                  Up;
  logic                  LzBlank;
  logic                  Blink;
  logic [4*DIGITS-1:0]   Value;
  logic                  Wrap;
  logic [7*DIGITS-1:0]   HEX;

  // Host side: drives controls, observes value and segments.
  modport master (
    output Load, Data, CountEn, Up, LzBlank, Blink,
    input  Value, Wrap, HEX
  );

  // Controller side.
  modport slave (
    input  Load, Data, CountEn, Up, LzBlank, Blink,
    output Value, Wrap, HEX
  );

endinterface

// File: rtl/hex_display_ctrl.sv
// Loadable up/down hex counter driving active-low 7-segment digits with
// leading-zero suppression and blinking.
module hex_display_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input logic               Clock,
  input logic               Reset,
  hex_display_ctrl_if.slave bus
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned HW = 7 * DIGITS;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [VW-1:0] value_q, value_d;
  logic          wrap_q, wrap_d;
  logic [HW-1:0] hex_q, hex_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Hex nibble to active-low gfedcba segments.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Prescaler and value update; Load wins over a coincident tick.
  always_comb begin
    pre_d   = '0;
    value_d = value_q;
    wrap_d  = 1'b0;
    if (bus.Load) begin
      value_d = bus.Data;
    end else if (bus.CountEn) begin
      if (pre_q == PRE_LAST) begin
        if (bus.Up) begin
          value_d = value_q + VW'(1);
          wrap_d  = &value_q;
        end else begin
          value_d = value_q - VW'(1);
          wrap_d  = ~|value_q;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Free-running blink divider; phase flips on each wrap.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Segment image: blink blanking, leading-zero suppression (digit 0 always shown).
  always_comb begin
    logic seen;
    logic [3:0] nib;
    seen  = 1'b0;
    nib   = '0;
    hex_d = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = value_q[4*i +: 4];
      if (nib != 4'h0) seen = 1'b1;
      if ((bus.Blink && phase_q) || (bus.LzBlank && !seen && i != 0))
        hex_d[7*i +: 7] = 7'b1111111;
      else
        hex_d[7*i +: 7] = seg7(nib);
    end
  end

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      value_q     <= '0;
      wrap_q      <= 1'b0;
      hex_q       <= '1;
      pre_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      value_q     <= value_d;
      wrap_q      <= wrap_d;
      hex_q       <= hex_d;
      pre_q       <= pre_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign bus.Value = value_q;
  assign bus.Wrap  = wrap_q;
  assign bus.HEX   = hex_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl against a cycle-level reference model.
module tb_hex_display_ctrl;

  localparam int DIGITS    = 4;
  localparam int TICK_DIV  = 4;
  localparam int BLINK_DIV = 3;

  logic Clock = 1'b0;
  logic Reset;

  hex_display_ctrl_if #(.DIGITS(DIGITS)) bus ();

  hex_display_ctrl #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          tag;
    logic [15:0] value;
    logic        wrap;
    logic [27:0] hex;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   tag_n = 0;
  event chk_ev;

  // Reference model state: value, consecutive counting cycles, edges since reset.
  int m_val   = 0;
  int m_run   = 0;
  int m_edges = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [27:0] disp(input int v, input bit lz, input bit blank);
    logic [27:0] r;
    int msd;
    int dg;
    r   = '1;
    msd = 0;
    for (int i = 0; i < DIGITS; i++)
      if (((v >> (4*i)) & 15) != 0) msd = i;
    for (int i = 0; i < DIGITS; i++) begin
      dg = (v >> (4*i)) & 15;
      if (blank || (lz && i > msd)) r[7*i +: 7] = 7'h7F;
      else                          r[7*i +: 7] = seg_tab[dg];
    end
    return r;
  endfunction

  task automatic check_one();
    exp_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    tests++;
    if (bus.Value !== e.value) begin
      fails++;
      $display("FAIL value tag=%0d got=%h want=%h", e.tag, bus.Value, e.value);
    end
    tests++;
    if (bus.Wrap !== e.wrap) begin
      fails++;
      $display("FAIL wrap tag=%0d got=%b want=%b", e.tag, bus.Wrap, e.wrap);
    end
    tests++;
    if (bus.HEX !== e.hex) begin
      fails++;
      $display("FAIL hex tag=%0d got=%h want=%h", e.tag, bus.HEX, e.hex);
    end
  endtask

  // Monitor: registered outputs just after each edge, plus asynchronous checks.
  always begin
    @(posedge Clock);
    #1;
    check_one();
  end

  always begin
    @(chk_ev);
    check_one();
  end

  function automatic exp_t reset_exp();
    exp_t e;
    e.tag   = tag_n;
    e.value = '0;
    e.wrap  = 1'b0;
    e.hex   = '1;
    return e;
  endfunction

  // Drive one cycle's inputs and predict the state after the coming edge.
  task automatic cycle(input bit rs, input bit ld, input logic [15:0] d,
                       input bit ce, input bit up, input bit lz, input bit bl);
    exp_t e;
    bit   ph;
    bit   tick;
    @(negedge Clock);
    Reset       = rs;
    bus.Load    = ld;
    bus.Data    = d;
    bus.CountEn = ce;
    bus.Up      = up;
    bus.LzBlank = lz;
    bus.Blink   = bl;
    if (rs) begin
      m_val = 0; m_run = 0; m_edges = 0;
      e = reset_exp();
    end else begin
      e.tag  = tag_n;
      ph     = ((m_edges / BLINK_DIV) % 2) == 1;
      e.hex  = disp(m_val, lz, bl && ph);
      tick   = ce && !ld && ((m_run % TICK_DIV) == TICK_DIV - 1);
      m_run  = (ce && !ld) ? m_run + 1 : 0;
      e.wrap = 1'b0;
      if (ld) begin
        m_val = int'(d);
      end else if (tick) begin
        if (up) begin
          e.wrap = (m_val == 65535);
          m_val  = (m_val + 1) % 65536;
        end else begin
          e.wrap = (m_val == 0);
          m_val  = (m_val + 65535) % 65536;
        end
      end
      m_edges++;
      e.value = 16'(m_val);
    end
    tag_n++;
    exp_q.push_back(e);
  endtask

  // Assert reset between edges and check that it takes effect immediately.
  task automatic async_reset();
    @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    m_val = 0; m_run = 0; m_edges = 0;
    exp_q.push_back(reset_exp());
    tag_n++;
    -> chk_ev;
  endtask

  initial begin
    logic [15:0] rd;
    Reset       = 1'b1;
    bus.Load    = 1'b0;
    bus.Data    = '0;
    bus.CountEn = 1'b0;
    bus.Up      = 1'b1;
    bus.LzBlank = 1'b0;
    bus.Blink   = 1'b0;
    #2;
    exp_q.push_back(reset_exp());
    tag_n++;
    -> chk_ev;

    // reset held, then released with Load=0
    repeat (2) cycle(1, 0, 16'h0, 0, 1, 0, 0);
    repeat (3) cycle(0, 0, 16'h0, 0, 1, 0, 0);
    // load 00A5 with leading-zero suppression
    cycle(0, 1, 16'h00A5, 0, 1, 1, 0);
    repeat (2) cycle(0, 0, 16'h0, 0, 1, 1, 0);
    // FFFE counting up through wrap
    cycle(0, 1, 16'hFFFE, 1, 1, 0, 0);
    repeat (10) cycle(0, 0, 16'h0, 1, 1, 0, 0);
    // 0000 counting down through wrap
    cycle(0, 1, 16'h0000, 1, 0, 0, 0);
    repeat (5) cycle(0, 0, 16'h0, 1, 0, 0, 0);
    // load coinciding with a wrapping tick
    cycle(0, 1, 16'h0000, 1, 0, 0, 0);
    repeat (3) cycle(0, 0, 16'h0, 1, 0, 0, 0);
    cycle(0, 1, 16'h1234, 1, 0, 0, 0);
    // blinking on 1234, then steady
    repeat (12) cycle(0, 0, 16'h0, 0, 1, 0, 1);
    repeat (6) cycle(0, 0, 16'h0, 0, 1, 0, 0);
    // async reset mid-count at prescaler 2, value 0007
    cycle(0, 1, 16'h0007, 0, 1, 0, 0);
    repeat (2) cycle(0, 0, 16'h0, 1, 1, 0, 0);
    async_reset();
    repeat (2) cycle(1, 0, 16'h0, 1, 1, 0, 0);
    repeat (10) cycle(0, 0, 16'h0, 1, 1, 0, 0);
    // randomized traffic biased toward wrap boundaries
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: rd = 16'hFFFF;
        1: rd = 16'h0000;
        2: rd = 16'hFFFD;
        default: rd = 16'($urandom);
      endcase
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, rd,
            $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    cycle(0, 0, 16'h0, 0, 1, 0, 0);

    @(posedge Clock);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout time=%0t limit=1000000", $time);
    $fatal(1, "timeout");
  end

endmodule
